// File: rtl/mem_wb_ctrl.sv
// mem_wb_ctrl: memory / write-back stage controller.
// Retires one decoded operation per cycle into the register file or the PC.
// Loads and stores go through a req/ack memory port with byte strobes.
// The pipeline is stalled while a memory request is outstanding.
//
//   state  | meaning
//   S_IDLE | accepting ops; non-memory ops retire in the next cycle
//   S_REQ  | memory request outstanding; stall held until memAck or timeout
module mem_wb_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     opValid,
  input  logic [3:0]               state,
  input  logic [2:0]               func3,
  input  logic [DATA_WIDTH-1:0]    aluO,
  input  logic [DATA_WIDTH-1:0]    imm,
  input  logic [DATA_WIDTH-1:0]    storeData,
  input  logic [ADDR_WIDTH-1:0]    opPc,
  output logic                     stall,
  output logic                     regWriteEnable,
  output logic [DATA_WIDTH-1:0]    regWriteData,
  output logic                     pcWriteEnable,
  output logic [ADDR_WIDTH-1:0]    pcWriteData,
  output logic                     memReq,
  output logic                     memWe,
  output logic [ADDR_WIDTH-1:0]    memAddr,
  output logic [DATA_WIDTH-1:0]    memWData,
  output logic [DATA_WIDTH/8-1:0]  memStrb,
  input  logic [DATA_WIDTH-1:0]    memRData,
  input  logic                     memAck,
  output logic                     excMisalign,
  output logic                     excTimeout
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  // Op codes shared with the decode stage.
  localparam logic [3:0] OP_IDLE   = 4'd0;
  localparam logic [3:0] OP_REG    = 4'd1;
  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_PCSEL  = 4'd4;
  localparam logic [3:0] OP_PCW    = 4'd5;
  localparam logic [3:0] OP_LUI    = 4'd6;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } fsm_e;

  fsm_e                  fsm_q, fsm_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  is_load_q, is_load_d;
  logic [2:0]            func3_q, func3_d;
  logic [OFF_W-1:0]      off_q, off_d;

  logic                  rwe_q, rwe_d;
  logic [DATA_WIDTH-1:0] rwd_q, rwd_d;
  logic                  pwe_q, pwe_d;
  logic [ADDR_WIDTH-1:0] pwd_q, pwd_d;
  logic                  mreq_q, mreq_d;
  logic                  mwe_q, mwe_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [DATA_WIDTH-1:0] mwdata_q, mwdata_d;
  logic [STRB_W-1:0]     mstrb_q, mstrb_d;
  logic                  mis_q, mis_d;
  logic                  to_q, to_d;

  logic                  accept;
  logic [OFF_W-1:0]      off_in;
  logic [OFF_W+2:0]      sh_in;
  logic [OFF_W+2:0]      sh_q;
  logic [STRB_W-1:0]     size_mask;
  logic [OFF_W-1:0]      align_mask;
  logic                  size_legal;
  logic                  aligned;
  logic [ADDR_WIDTH-1:0] alu_addr;
  logic [ADDR_WIDTH-1:0] pc_plus4;
  logic [DATA_WIDTH-1:0] rdata_sh;
  logic [DATA_WIDTH-1:0] load_data;
  logic [CNT_W-1:0]      cnt_inc;

  assign stall    = (fsm_q == S_REQ);
  assign accept   = opValid && !stall;
  assign off_in   = aluO[OFF_W-1:0];
  assign sh_in    = {off_in, 3'b000};
  assign sh_q     = {off_q, 3'b000};
  assign alu_addr = ADDR_WIDTH'(aluO);
  assign pc_plus4 = opPc + ADDR_WIDTH'(4);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Access size decode: byte mask, alignment mask and width legality.
  always_comb begin
    size_mask  = '0;
    align_mask = '0;
    case (func3[1:0])
      2'b00: begin size_mask = STRB_W'(1);   align_mask = OFF_W'(0); end
      2'b01: begin size_mask = STRB_W'(3);   align_mask = OFF_W'(1); end
      2'b10: begin size_mask = STRB_W'(15);  align_mask = OFF_W'(3); end
      default: begin size_mask = STRB_W'(255); align_mask = OFF_W'(7); end
    endcase
    // 64-bit and unsigned-word accesses only exist on the 64-bit datapath;
    // func3 = 111 is never a valid access.
    size_legal = (func3 != 3'b111) &&
                 !(((func3 == 3'b011) || (func3 == 3'b110)) && (DATA_WIDTH != 64));
    aligned    = size_legal && ((off_in & align_mask) == '0);
  end

  // Load lane extraction and sign/zero extension.
  always_comb begin
    rdata_sh  = memRData >> sh_q;
    load_data = rdata_sh;
    case (func3_q)
      3'b000:  load_data = DATA_WIDTH'($signed(rdata_sh[7:0]));
      3'b001:  load_data = DATA_WIDTH'($signed(rdata_sh[15:0]));
      3'b010:  load_data = DATA_WIDTH'($signed(rdata_sh[31:0]));
      3'b100:  load_data = DATA_WIDTH'(rdata_sh[7:0]);
      3'b101:  load_data = DATA_WIDTH'(rdata_sh[15:0]);
      3'b110:  load_data = DATA_WIDTH'(rdata_sh[31:0]);
      default: load_data = rdata_sh;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    is_load_d = is_load_q;
    func3_d   = func3_q;
    off_d     = off_q;
    rwe_d     = 1'b0;
    rwd_d     = rwd_q;
    pwe_d     = 1'b0;
    pwd_d     = pwd_q;
    mreq_d    = mreq_q;
    mwe_d     = mwe_q;
    maddr_d   = maddr_q;
    mwdata_d  = mwdata_q;
    mstrb_d   = mstrb_q;
    mis_d     = 1'b0;
    to_d      = 1'b0;

    case (fsm_q)
      S_IDLE: begin
        if (accept) begin
          case (state)
            OP_REG: begin
              rwe_d = 1'b1;
              rwd_d = aluO;
            end
            OP_LUI: begin
              rwe_d = 1'b1;
              rwd_d = imm;
            end
            OP_PCW: begin
              pwe_d = 1'b1;
              pwd_d = alu_addr & ~ADDR_WIDTH'(1);
              rwe_d = 1'b1;
              rwd_d = DATA_WIDTH'(pc_plus4);
            end
            OP_PCSEL: begin
              if (aluO[0]) begin
                pwe_d = 1'b1;
                pwd_d = opPc + ADDR_WIDTH'(imm);
              end
            end
            OP_LOAD, OP_STORE: begin
              if (!aligned) begin
                mis_d = 1'b1;
              end else begin
                fsm_d     = S_REQ;
                cnt_d     = '0;
                is_load_d = (state == OP_LOAD);
                func3_d   = func3;
                off_d     = off_in;
                mreq_d    = 1'b1;
                mwe_d     = (state == OP_STORE);
                maddr_d   = alu_addr & ~ADDR_WIDTH'(STRB_W - 1);
                mstrb_d   = size_mask << off_in;
                mwdata_d  = storeData << sh_in;
              end
            end
            default: ;
          endcase
        end
      end

      S_REQ: begin
        // memAck wins over a coincident timeout.
        if (memAck) begin
          fsm_d   = S_IDLE;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          mstrb_d = '0;
          cnt_d   = '0;
          if (is_load_q) begin
            rwe_d = 1'b1;
            rwd_d = load_data;
          end
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          fsm_d   = S_IDLE;
          mreq_d  = 1'b0;
          mwe_d   = 1'b0;
          mstrb_d = '0;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: fsm_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= S_IDLE;
      cnt_q     <= '0;
      is_load_q <= 1'b0;
      func3_q   <= '0;
      off_q     <= '0;
      rwe_q     <= 1'b0;
      rwd_q     <= '0;
      pwe_q     <= 1'b0;
      pwd_q     <= '0;
      mreq_q    <= 1'b0;
      mwe_q     <= 1'b0;
      maddr_q   <= '0;
      mwdata_q  <= '0;
      mstrb_q   <= '0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      fsm_q     <= fsm_d;
      cnt_q     <= cnt_d;
      is_load_q <= is_load_d;
      func3_q   <= func3_d;
      off_q     <= off_d;
      rwe_q     <= rwe_d;
      rwd_q     <= rwd_d;
      pwe_q     <= pwe_d;
      pwd_q     <= pwd_d;
      mreq_q    <= mreq_d;
      mwe_q     <= mwe_d;
      maddr_q   <= maddr_d;
      mwdata_q  <= mwdata_d;
      mstrb_q   <= mstrb_d;
      mis_q     <= mis_d;
      to_q      <= to_d;
    end
  end

  assign regWriteEnable = rwe_q;
  assign regWriteData   = rwd_q;
  assign pcWriteEnable  = pwe_q;
  assign pcWriteData    = pwd_q;
  assign memReq         = mreq_q;
  assign memWe          = mwe_q;
  assign memAddr        = maddr_q;
  assign memWData       = mwdata_q;
  assign memStrb        = mstrb_q;
  assign excMisalign    = mis_q;
  assign excTimeout     = to_q;

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Directed bench for mem_wb_ctrl (32-bit datapath, TIMEOUT = 15).
module tb_mem_wb_ctrl;

  localparam logic [3:0] OP_IDLE  = 4'd0;
  localparam logic [3:0] OP_REG   = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_STORE = 4'd3;
  localparam logic [3:0] OP_PCSEL = 4'd4;
  localparam logic [3:0] OP_PCW   = 4'd5;
  localparam logic [3:0] OP_LUI   = 4'd6;

  logic        clk = 1'b0;
  logic        reset;
  logic        opValid;
  logic [3:0]  state;
  logic [2:0]  func3;
  logic [31:0] aluO, imm, storeData, opPc;
  logic        stall, regWriteEnable, pcWriteEnable;
  logic [31:0] regWriteData, pcWriteData;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWData, memRData;
  logic [3:0]  memStrb;
  logic        memAck, excMisalign, excTimeout;

  int n_cmp = 0;
  int n_bad = 0;

  mem_wb_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .opValid(opValid), .state(state), .func3(func3),
    .aluO(aluO), .imm(imm), .storeData(storeData), .opPc(opPc),
    .stall(stall), .regWriteEnable(regWriteEnable), .regWriteData(regWriteData),
    .pcWriteEnable(pcWriteEnable), .pcWriteData(pcWriteData),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memStrb(memStrb), .memRData(memRData), .memAck(memAck),
    .excMisalign(excMisalign), .excTimeout(excTimeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] im, input logic [31:0] sd, input logic [31:0] pc);
    opValid = 1'b1; state = op; func3 = f3; aluO = a; imm = im; storeData = sd; opPc = pc;
    tick();
    opValid = 1'b0; state = OP_IDLE;
  endtask

  // Byte load from 0x103 with memAck on the third request cycle.
  task automatic byte_load(input string tag, input logic [2:0] f3, input logic [31:0] exp);
    int stall_cycles;
    issue(OP_LOAD, f3, 32'h103, 32'h0, 32'h0, 32'h0);
    chk({tag, "_req"},  memReq,  1);
    chk({tag, "_addr"}, memAddr, 32'h100);
    chk({tag, "_strb"}, memStrb, 4'b1000);
    chk({tag, "_we"},   memWe,   0);
    stall_cycles = 0;
    for (int c = 1; c <= 3; c++) begin
      if (stall) stall_cycles++;
      if (c == 3) begin
        memAck = 1'b1;
        memRData = 32'h80FF_FF00;
      end
      tick();
      memAck = 1'b0;
      memRData = 32'h0;
    end
    chk({tag, "_stall_cycles"}, stall_cycles, 3);
    chk({tag, "_stall_drop"},   stall, 0);
    chk({tag, "_req_drop"},     memReq, 0);
    chk({tag, "_rwe"},          regWriteEnable, 1);
    chk({tag, "_rwd"},          regWriteData, exp);
    tick();
    chk({tag, "_rwe_pulse"},    regWriteEnable, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; opValid = 1'b0; state = OP_IDLE; func3 = 3'b0;
    aluO = '0; imm = '0; storeData = '0; opPc = '0; memRData = '0; memAck = 1'b0;
    tick(); tick();
    chk("rst_rwe",   regWriteEnable, 0);
    chk("rst_req",   memReq, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pwe",   pcWriteEnable, 0);
    reset = 1'b0;
    tick();

    // RegWrite
    issue(OP_REG, 3'b0, 32'h0000_1234, 32'h0, 32'h0, 32'h0);
    chk("reg_rwe", regWriteEnable, 1);
    chk("reg_rwd", regWriteData, 32'h1234);
    tick();
    chk("reg_rwe_pulse", regWriteEnable, 0);

    // LUI
    issue(OP_LUI, 3'b0, 32'h0, 32'h1234_5000, 32'h0, 32'h0);
    chk("lui_rwd", regWriteData, 32'h1234_5000);
    chk("lui_pwe", pcWriteEnable, 0);

    byte_load("lb",  3'b000, 32'hFFFF_FF80);
    byte_load("lbu", 3'b100, 32'h0000_0080);

    // SH at 0x202, ack on the first request cycle
    issue(OP_STORE, 3'b001, 32'h202, 32'h0, 32'h0000_ABCD, 32'h0);
    chk("sh_strb",  memStrb, 4'b1100);
    chk("sh_wdata", memWData, 32'hABCD_0000);
    chk("sh_we",    memWe, 1);
    chk("sh_addr",  memAddr, 32'h200);
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    chk("sh_rwe",   regWriteEnable, 0);
    chk("sh_stall", stall, 0);
    chk("sh_req",   memReq, 0);

    // Misaligned LW
    issue(OP_LOAD, 3'b010, 32'h101, 32'h0, 32'h0, 32'h0);
    chk("lw_mis",   excMisalign, 1);
    chk("lw_req",   memReq, 0);
    chk("lw_stall", stall, 0);
    chk("lw_rwe",   regWriteEnable, 0);
    tick();
    chk("lw_mis_pulse", excMisalign, 0);
    chk("lw_req2",      memReq, 0);

    // Double-word access is illegal on the 32-bit datapath
    issue(OP_LOAD, 3'b011, 32'h100, 32'h0, 32'h0, 32'h0);
    chk("ld32_mis", excMisalign, 1);
    chk("ld32_req", memReq, 0);

    // Stray memAck while idle is ignored
    memAck = 1'b1;
    tick();
    memAck = 1'b0;
    chk("stray_ack_rwe", regWriteEnable, 0);

    // Branch taken / not taken, jump
    issue(OP_PCSEL, 3'b0, 32'h1, 32'h10, 32'h0, 32'h40);
    chk("br_pwe", pcWriteEnable, 1);
    chk("br_pwd", pcWriteData, 32'h50);
    chk("br_rwe", regWriteEnable, 0);
    issue(OP_PCSEL, 3'b0, 32'h0, 32'h10, 32'h0, 32'h40);
    chk("brnt_pwe", pcWriteEnable, 0);
    issue(OP_PCW, 3'b0, 32'h81, 32'h0, 32'h0, 32'h40);
    chk("jmp_pwe", pcWriteEnable, 1);
    chk("jmp_pwd", pcWriteData, 32'h80);
    chk("jmp_rwe", regWriteEnable, 1);
    chk("jmp_rwd", regWriteData, 32'h44);

    // Store timeout: memAck never arrives
    issue(OP_STORE, 3'b010, 32'h300, 32'h0, 32'hDEAD_BEEF, 32'h0);
    n = 0;
    while (memReq && n < 40) begin
      n++;
      tick();
    end
    chk("to_req_cycles", n, 15);
    chk("to_exc",   excTimeout, 1);
    chk("to_req",   memReq, 0);
    chk("to_stall", stall, 0);
    chk("to_rwe",   regWriteEnable, 0);
    tick();
    chk("to_exc_pulse", excTimeout, 0);

    // Reset on the 2nd request cycle of a store
    issue(OP_STORE, 3'b000, 32'h401, 32'h0, 32'h0000_0055, 32'h0);
    chk("rs_strb", memStrb, 4'b0010);
    chk("rs_wdata", memWData, 32'h0000_5500);
    tick();
    chk("rs_req_c2", memReq, 1);
    reset = 1'b1;
    tick();
    chk("rs_req",   memReq, 0);
    chk("rs_stall", stall, 0);
    chk("rs_we",    memWe, 0);
    chk("rs_strb0", memStrb, 0);
    chk("rs_rwe",   regWriteEnable, 0);
    chk("rs_to",    excTimeout, 0);
    chk("rs_mis",   excMisalign, 0);
    reset = 1'b0;
    tick();
    chk("rs_idle_stall", stall, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
